// File: rtl/cic_stereo_collector_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cic_pkg
//  Brief    : Shared types and constants for the CIC stereo collector.
//  Revision : 1.0 - initial release
// ============================================================================
package cic_pkg;

    localparam int SAMPLE_W = 16;

    localparam logic CH_LEFT  = 1'b0;
    localparam logic CH_RIGHT = 1'b1;

    typedef enum logic [0:0] {
        WAIT_L = 1'b0,
        WAIT_R = 1'b1
    } state_t;

endpackage : cic_pkg
`default_nettype wire

// File: rtl/cic_stereo_collector_if.sv
`default_nettype none
// ============================================================================
//  Module   : cic_stereo_collector_if
//  Brief    : Channel-tagged sample sink plus stereo pair source handshakes.
//  Revision : 1.0 - initial release
// ============================================================================
interface cic_stereo_collector_if
    import cic_pkg::*;
#(
    parameter int DATA_W = SAMPLE_W
);
    logic [DATA_W-1:0] snk_data;
    logic              snk_channel;
    logic              snk_valid;
    logic              snk_ready;
    logic [1:0]        snk_error;
    logic              snk_sop;
    logic              snk_eop;

    logic [DATA_W-1:0] pair_left;
    logic [DATA_W-1:0] pair_right;
    logic              pair_valid;
    logic              pair_ready;

    // Environment side: CIC source and mixer consumer.
    modport master (
        output snk_data, snk_channel, snk_valid, snk_error, snk_sop, snk_eop,
        input  snk_ready,
        input  pair_left, pair_right, pair_valid,
        output pair_ready
    );

    // Collector side.
    modport slave (
        input  snk_data, snk_channel, snk_valid, snk_error, snk_sop, snk_eop,
        output snk_ready,
        output pair_left, pair_right, pair_valid,
        input  pair_ready
    );

endinterface : cic_stereo_collector_if
`default_nettype wire

// File: rtl/cic_stereo_collector_pair_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : pair_fifo
//  Brief    : Synchronous show-ahead FIFO; head entry is always on rd_data.
//  Revision : 1.0 - initial release
// ============================================================================
module pair_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  wire logic             clk,
    input  wire logic             reset_n,
    input  wire logic             push,
    input  wire logic [WIDTH-1:0] wr_data,
    input  wire logic             pop,
    output logic      [WIDTH-1:0] rd_data,
    output logic                  full,
    output logic                  empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [AW-1:0] c_ptr_one = AW'(1);
    localparam logic [CW-1:0] c_cnt_one = CW'(1);
    localparam logic [CW-1:0] c_cnt_max = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push  = push && !full;
    assign w_pop   = pop && !empty;
    assign full    = (r_count == c_cnt_max);
    assign empty   = (r_count == '0);
    assign rd_data = r_mem[r_rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= wr_data;
                r_wr_ptr        <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : pair_fifo
`default_nettype wire

// File: rtl/cic_stereo_collector.sv
`default_nettype none
// ============================================================================
//  Module   : cic_stereo_collector
//  Brief    : Pairs left/right CIC samples into a FIFO for the mixer and
//             keeps sticky sequence/error status.
//  Revision : 1.0 - initial release
// ============================================================================
module cic_stereo_collector
    import cic_pkg::*;
#(
    parameter int DATA_W     = SAMPLE_W,
    parameter int FIFO_DEPTH = 4,
    parameter int ERR_CNT_W  = 8
) (
    input  wire logic                 clk,
    input  wire logic                 reset_n,
    cic_stereo_collector_if.slave     bus,
    output logic                      seq_err,
    output logic [ERR_CNT_W-1:0]      err_count,
    input  wire logic                 status_clr
);
    localparam logic [ERR_CNT_W-1:0] c_err_one = ERR_CNT_W'(1);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [DATA_W-1:0]       r_hold_l;
    logic                    r_seq_err;
    logic [ERR_CNT_W-1:0]    r_err_count;

    logic                    w_accept;
    logic                    w_errored;
    logic                    w_push;
    logic                    w_hold_ld;
    logic                    w_seq_set;
    logic                    w_err_inc;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_pop;
    logic [2*DATA_W-1:0]     w_head;
    logic                    w_unused_framing;

    // Packet framing carries no meaning for pairing.
    assign w_unused_framing = bus.snk_sop ^ bus.snk_eop;

    assign bus.snk_ready = reset_n && ((r_state == WAIT_L) || !w_full);
    assign w_accept      = bus.snk_valid && bus.snk_ready;
    assign w_errored     = |bus.snk_error;

    assign w_pop          = !w_empty && bus.pair_ready;
    assign bus.pair_valid = !w_empty;
    assign bus.pair_left  = w_head[2*DATA_W-1:DATA_W];
    assign bus.pair_right = w_head[DATA_W-1:0];

    assign seq_err   = r_seq_err;
    assign err_count = r_err_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= WAIT_L;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_hold_ld   = 1'b0;
        w_seq_set   = 1'b0;
        w_err_inc   = 1'b0;
        if (w_accept) begin
            if (w_errored) begin
                // Abandon any half-built pair so the next left starts fresh.
                w_err_inc   = 1'b1;
                w_state_nxt = WAIT_L;
            end else begin
                case (r_state)
                    WAIT_L: begin
                        if (bus.snk_channel == CH_LEFT) begin
                            w_hold_ld   = 1'b1;
                            w_state_nxt = WAIT_R;
                        end else begin
                            w_seq_set = 1'b1;
                        end
                    end
                    WAIT_R: begin
                        if (bus.snk_channel == CH_RIGHT) begin
                            w_push      = 1'b1;
                            w_state_nxt = WAIT_L;
                        end else begin
                            w_hold_ld = 1'b1;
                            w_seq_set = 1'b1;
                        end
                    end
                    default: w_state_nxt = WAIT_L;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hold_l    <= '0;
            r_seq_err   <= 1'b0;
            r_err_count <= '0;
        end else begin
            if (w_hold_ld) begin
                r_hold_l <= bus.snk_data;
            end
            // A clear in the same cycle as a new event wins.
            if (status_clr) begin
                r_seq_err   <= 1'b0;
                r_err_count <= '0;
            end else begin
                if (w_seq_set) begin
                    r_seq_err <= 1'b1;
                end
                if (w_err_inc && !(&r_err_count)) begin
                    r_err_count <= r_err_count + c_err_one;
                end
            end
        end
    end

    pair_fifo #(
        .WIDTH (2*DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_pair_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (w_push),
        .wr_data ({r_hold_l, bus.snk_data}),
        .pop     (w_pop),
        .rd_data (w_head),
        .full    (w_full),
        .empty   (w_empty)
    );

endmodule : cic_stereo_collector
`default_nettype wire

// File: doc/cic_stereo_collector.md
Name: cic_stereo_collector

Overview:
- Downstream sink for the 16-bit channel-tagged Avalon-ST output of the decimating CIC rate converter.
- Pairs channel 0 (left) with the following channel 1 (right) sample and buffers the pairs in a small show-ahead FIFO.
- Presents each pair to the mixer through a valid/ready handshake.
- Drops errored or out-of-sequence samples and keeps sticky status for the host register file.

Parameters:
- DATA_W, 16, sample width in bits.
- FIFO_DEPTH, 4, pair FIFO depth in entries; must be a power of 2, minimum 2.
- ERR_CNT_W, 8, width of the saturating errored-sample counter.

Ports:
- clk  in  1  system clock; one clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- snk_data  in  DATA_W  sample from the CIC stage.
- snk_channel  in  1  0 = left, 1 = right.
- snk_valid  in  1  sample valid.
- snk_ready  out  1  block can accept a sample.
- snk_error  in  2  nonzero = errored sample.
- snk_sop  in  1  start of packet; ignored, kept for interface compatibility.
- snk_eop  in  1  end of packet; ignored, kept for interface compatibility.
- pair_left  out  DATA_W  left sample of the FIFO head.
- pair_right  out  DATA_W  right sample of the FIFO head.
- pair_valid  out  1  FIFO head valid.
- pair_ready  in  1  consumer accepts the head.
- seq_err  out  1  sticky: channel sequence violation seen.
- err_count  out  ERR_CNT_W  saturating count of samples with snk_error != 0.
- status_clr  in  1  synchronous clear of seq_err and err_count.

Behaviour:
- Reset (reset_n low, asynchronous):
  - state = WAIT_L, hold_l = 0, FIFO empty, pointers 0.
  - seq_err = 0, err_count = 0, pair_valid = 0, pair_left/right = 0, snk_ready = 0.
  - Reset mid-pair discards the held left sample and all FIFO contents.
- Accept condition: accept = snk_valid && snk_ready.
- snk_ready (combinational, no dependence on snk_valid or pair_ready):
  - 0 while reset_n is low.
  - 1 in WAIT_L.
  - In WAIT_R: equal to !full.
- Errored accepted sample (snk_error != 0):
  - Discarded; err_count increments, saturating at all-ones.
  - State returns to WAIT_L and any held left sample is abandoned.
  - seq_err is not touched.
- State WAIT_L, clean sample accepted:
  - ch0: hold_l <= snk_data, go to WAIT_R.
  - ch1: discard, set seq_err, stay in WAIT_L.
- State WAIT_R, clean sample accepted:
  - ch1: push {hold_l, snk_data} into the FIFO, go to WAIT_L.
  - ch0: overwrite hold_l, set seq_err, stay in WAIT_R.
- FIFO:
  - Show-ahead: pair_valid = !empty; pair_left/right = head entry.
  - Pop on pair_valid && pair_ready.
  - Push and pop in the same cycle: count unchanged.
  - Push when full cannot occur, because snk_ready is low.
  - Pointers wrap modulo FIFO_DEPTH; count width is log2(FIFO_DEPTH)+1.
  - When empty, pair_left/right hold the last head value; contents are don't-care.
- Latency: a right sample accepted at edge N into an empty FIFO gives pair_valid = 1 after edge N. The pair is visible in the cycle following the accept.
- status_clr:
  - Clears seq_err and err_count on the next edge.
  - If a new event occurs in the same cycle, clear wins and the event is lost.
  - Does not affect state or the FIFO.
- Arithmetic: none on data; samples pass bit-exact.

Decomposition:
- Shared package cic_pkg holds:
  - the state enum {WAIT_L, WAIT_R};
  - the constants CH_LEFT = 0 and CH_RIGHT = 1;
  - the default sample width 16.
- One sub-module, pair_fifo: parameterised synchronous show-ahead FIFO with width 2*DATA_W, depth FIFO_DEPTH, and full/empty flags.
- The pairing state machine and status counters stay in the top module.

Test Plan:
- Pairing: send ch0 = 0x1234, then ch1 = 0xABCD, with pair_ready = 1. Expect pair_valid one cycle after the right sample is accepted, pair_left = 0x1234, pair_right = 0xABCD, and pair_valid low after the pop.
- Sequence error: send ch1 = 0x0001 in WAIT_L, then ch0 = 0x1111, ch0 = 0x2222, ch1 = 0x3333. Expect seq_err = 1 and exactly one pair {0x2222, 0x3333}.
- Backpressure: hold pair_ready = 0 and send 5 L/R pairs. Expect:
  - 4 pairs stored;
  - snk_ready = 0 in WAIT_R after the 5th left is accepted;
  - releasing pair_ready drains all 5 pairs in order, with no loss or duplication.
- Error handling: send an L sample with snk_error = 2'b01 in WAIT_R (after a clean L of 0x0AAA), then ch1 = 0x0BBB. Expect:
  - err_count = 1;
  - the 0x0BBB right sample arrives in WAIT_L and sets seq_err;
  - no pair is produced.
- Counter saturation: send 300 errored samples with ERR_CNT_W = 8. Expect err_count = 255. Then pulse status_clr: err_count = 0 and seq_err = 0.
- Asynchronous reset: assert reset_n low mid-cycle with the FIFO holding 2 pairs and the state in WAIT_R. Expect pair_valid = 0 and snk_ready = 0 immediately. After release, expect WAIT_L behaviour and an empty FIFO.
